// File: rtl/serial_sum_collector.sv
// rtl/serial_sum_collector.sv - deserialises an LSB-first serial sum into a parallel word behind a valid/ready handshake
// Optional feature macro: SUM_CARRY_EN (adds the carry_out port and its register)
module serial_sum_collector #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             reset,
  input  logic             start,
  input  logic             s_bit,
  input  logic             c_bit,
  input  logic             res_ready,
  output logic             busy,
  output logic             res_valid,
  output logic [WIDTH-1:0] sum_out,
`ifdef SUM_CARRY_EN
  output logic [CNT_W-1:0] bit_cnt,
  output logic             carry_out
`else
  output logic [CNT_W-1:0] bit_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shift_val;
  logic             last_bit;
  logic             word_load;
  logic             result_take;

  // Incoming bit enters at the MSB so that after WIDTH shifts the first bit sits at bit 0.
  assign shift_val = {s_bit, shreg[WIDTH-1:1]};

  // Final bit of the word is being sampled this cycle.
  assign last_bit = (state == COLLECT) && (bit_cnt == CNT_ONE);

  // Consumer takes the held result this cycle.
  assign result_take = (state == DONE) && res_ready;

  // A new word is armed from IDLE, or straight out of DONE when the handshake completes.
  assign word_load = start && ((state == IDLE) || result_take);

  // busy is a pure decode of the state register.
  assign busy = (state != IDLE);

  // State register.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state selection.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (bit_cnt == CNT_ONE) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_nxt = start ? COLLECT : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Shift register: cleared when a word is armed, shifts on every COLLECT cycle.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      shreg <= '0;
    end else if (word_load) begin
      shreg <= '0;
    end else if (state == COLLECT) begin
      shreg <= shift_val;
    end
  end

  // Bit counter: loads WIDTH on arm, counts down while collecting, rests at 0 otherwise.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      bit_cnt <= CNT_ZERO;
    end else if (word_load) begin
      bit_cnt <= CNT_LOAD;
    end else if (state == COLLECT) begin
      bit_cnt <= bit_cnt - CNT_ONE;
    end else begin
      bit_cnt <= CNT_ZERO;
    end
  end

  // Result register: captured on the final bit and held (even after the handshake) until the next word completes.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      sum_out <= '0;
    end else if (last_bit) begin
      sum_out <= shift_val;
    end
  end

  // Valid flag: raised with the captured result, dropped only by the handshake.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      res_valid <= 1'b0;
    end else if (last_bit) begin
      res_valid <= 1'b1;
    end else if (result_take) begin
      res_valid <= 1'b0;
    end
  end

`ifdef SUM_CARRY_EN
  // Final adder carry travels alongside the sum and is held with it.
  always_ff @(posedge i_clk) begin
    if (reset) begin
      carry_out <= 1'b0;
    end else if (last_bit) begin
      carry_out <= c_bit;
    end
  end

  logic unused_bits;
  assign unused_bits = shreg[0];
`else
  logic unused_bits;
  assign unused_bits = ^{shreg[0], c_bit};
`endif

endmodule
